// File: rtl/sha256_engine.sv
// SHA-256 compression engine: fetches a 16-word block over the rq/rdy bus and compresses it onto a midstate.
// An optional second pass hashes the 256-bit digest again (SHA-256d); UNROLL rounds are computed per clock.
module sha256_engine #(
  parameter int UNROLL = 1,
  parameter int DBL_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         dbl,
  input  logic         abort,
  input  logic         rdy,
  input  logic [31:0]  data,
  output logic [3:0]   addr,
  output logic         rq,
  input  logic [255:0] state_in,
  output logic [255:0] state_out,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_COMP1 = 3'd2;
  localparam logic [2:0] S_FIN1  = 3'd3;
  localparam logic [2:0] S_COMP2 = 3'd4;
  localparam logic [2:0] S_FIN2  = 3'd5;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] sched(input logic [31:0] w2, input logic [31:0] w7,
                                        input logic [31:0] w15, input logic [31:0] w16);
    logic [31:0] s0;
    logic [31:0] s1;
    s0 = ror(w15, 5'd7) ^ ror(w15, 5'd18) ^ (w15 >> 3);
    s1 = ror(w2, 5'd17) ^ ror(w2, 5'd19) ^ (w2 >> 10);
    return s1 + w7 + s0 + w16;
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] v, input logic [31:0] k,
                                             input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = v;
    t1 = h + (ror(e, 5'd6) ^ ror(e, 5'd11) ^ ror(e, 5'd25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 5'd2) ^ ror(a, 5'd13) ^ ror(a, 5'd22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = 256'd0;
    for (int j = 0; j < 8; j++) begin
      r[j*32 +: 32] = x[j*32 +: 32] + y[j*32 +: 32];
    end
    return r;
  endfunction

  logic [2:0]   state_r;
  logic [31:0]  w_buf_r [16];
  logic [255:0] wv_r;
  logic [255:0] h_r;
  logic [5:0]   rnd_r;
  logic         dbl_r;

  logic [31:0]  wb_s [16];
  logic [255:0] wv_s;
  logic [255:0] sum_s;
  logic         last_s;

  assign sum_s  = add8(h_r, wv_r);
  assign last_s = (({1'b0, rnd_r} + 7'(UNROLL)) == 7'd64);

  // Unrolled rounds; a schedule word produced early in the chain feeds later rounds of the same cycle.
  always_comb begin
    logic [5:0] ri;
    logic [3:0] ix;
    ri   = 6'd0;
    ix   = 4'd0;
    wb_s = w_buf_r;
    wv_s = wv_r;
    for (int u = 0; u < UNROLL; u++) begin
      ri = rnd_r + 6'(u);
      ix = ri[3:0];
      wb_s[ix] = (ri >= 6'd16) ? sched(wb_s[ix - 4'd2], wb_s[ix - 4'd7], wb_s[ix + 4'd1], wb_s[ix])
                               : wb_s[ix];
      wv_s = sha_round(wv_s, K[ri], wb_s[ix]);
    end
  end

  // Control FSM, word fetch, round state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      rq        <= 1'b0;
      addr      <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      state_out <= 256'd0;
      wv_r      <= 256'd0;
      h_r       <= 256'd0;
      rnd_r     <= 6'd0;
      dbl_r     <= 1'b0;
      for (int j = 0; j < 16; j++) begin
        w_buf_r[j] <= 32'd0;
      end
    end else if (abort) begin
      state_r <= S_IDLE;
      rq      <= 1'b0;
      addr    <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_LOAD;
            rq      <= 1'b1;
            addr    <= 4'd0;
            busy    <= 1'b1;
            dbl_r   <= dbl & (DBL_EN != 0);
          end
        end
        S_LOAD: begin
          if (rdy) begin
            w_buf_r[addr] <= data;
            addr          <= addr + 4'd1;
            if (addr == 4'd15) begin
              rq      <= 1'b0;
              wv_r    <= state_in;
              h_r     <= state_in;
              rnd_r   <= 6'd0;
              state_r <= S_COMP1;
            end
          end
        end
        S_COMP1, S_COMP2: begin
          wv_r    <= wv_s;
          w_buf_r <= wb_s;
          rnd_r   <= rnd_r + 6'(UNROLL);
          if (last_s) begin
            state_r <= (state_r == S_COMP1) ? S_FIN1 : S_FIN2;
          end
        end
        S_FIN1: begin
          if (dbl_r) begin
            // Second pass block: first digest, padding bit, then the 256-bit message length.
            for (int j = 0; j < 8; j++) begin
              w_buf_r[j] <= sum_s[255 - 32*j -: 32];
            end
            w_buf_r[8] <= 32'h80000000;
            for (int j = 9; j < 15; j++) begin
              w_buf_r[j] <= 32'd0;
            end
            w_buf_r[15] <= 32'h00000100;
            wv_r    <= IV;
            h_r     <= IV;
            rnd_r   <= 6'd0;
            state_r <= S_COMP2;
          end else begin
            state_out <= sum_s;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
        S_FIN2: begin
          state_out <= sum_s;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_r   <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          rq      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
